// File: rtl/cpu_snoop_pkg.sv
// Shared definitions for the CPU write snooper: FSM states, frame buffer
// geometry, write-slot phases and the frame buffer window test.
package cpu_snoop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH_HI  = 2'd1,
    ST_PUSH_LO  = 2'd2,
    ST_WAIT_END = 2'd3
  } state_e;

  localparam logic [23:0] LINE_BYTES = 24'd64;
  localparam logic [23:0] FB_LINES   = 24'd342;
  localparam logic [23:0] FB_BYTES   = LINE_BYTES * FB_LINES;  // 21888

  // Phases of the 8-pixel group used for the VRAM write slot.
  localparam logic [2:0] SLOT_START = 3'd2;
  localparam logic [2:0] SLOT_WE    = 3'd3;
  localparam logic [2:0] SLOT_END   = 3'd4;

  // FIFO entry: {vram byte address[14:0], byte data[7:0]}.
  localparam int unsigned ENTRY_W = 23;

  // True when a byte address falls inside the frame buffer window at base.
  function automatic logic fb_hit(input logic [23:0] byte_addr,
                                  input logic [23:0] base);
    logic [23:0] offset;
    offset = byte_addr - base;
    return (byte_addr >= base) && (offset < FB_BYTES);
  endfunction

endpackage

// File: rtl/cpu_snoop_fifo.sv
// Small synchronous FIFO holding snooped bytes until a VRAM write slot.
// A push into a full FIFO is accepted only when a pop happens on the same cycle.
module snoop_fifo
  import cpu_snoop_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               wr_en_s, rd_en_s;

  assign empty   = (count_q == {(AW+1){1'b0}});
  assign full    = (count_q == CNT_FULL);
  assign rd_en_s = pop & ~empty;
  assign wr_en_s = push & (~full | rd_en_s);
  assign dout    = mem_q[rd_ptr_q];

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/cpu_snoop.sv
// Snoops 68000 writes into the screen buffer and replays them into VRAM
// during the seq 2..4 slot of each 8-pixel group.
module cpu_snoop
  import cpu_snoop_pkg::*;
#(
  parameter logic [23:0] FB_BASE    = 24'h3FA700,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        pixClock,
  input  logic        nReset,
  input  logic [22:0] cpuAddr,
  input  logic [15:0] cpuData,
  input  logic        nAS,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        cpuRnW,
  input  logic [2:0]  seq,
  output logic [14:0] vramWrAddr,
  output logic [7:0]  vramWrData,
  output logic        vramAddrSel,
  output logic        nvramWE,
  output logic        overflow
);

  logic [3:0]  strb_meta_q, strb_sync_q;   // {nAS, nUDS, nLDS, cpuRnW}
  logic [22:0] addr_q;
  logic [15:0] data_q;
  logic        as_n_s, uds_n_s, lds_n_s, rnw_s;
  logic [23:0] byte_addr_s;
  logic [14:0] off_lo_s;
  logic        hit_s, wr_detect_s;

  state_e      state_q, state_d;
  logic [14:0] offset_q, offset_d;
  logic [15:0] wdata_q, wdata_d;
  logic        uds_sel_q, uds_sel_d, lds_sel_q, lds_sel_d;
  logic        push_s, pop_s;
  logic [ENTRY_W-1:0] push_data_s, fifo_dout_s;
  logic        fifo_full_s, fifo_empty_s;

  logic        slot_q, slot_d;
  logic [14:0] vram_wr_addr_q, vram_wr_addr_d;
  logic [7:0]  vram_wr_data_q, vram_wr_data_d;
  logic        vram_addr_sel_q, vram_addr_sel_d;
  logic        nvram_we_q, nvram_we_d;
  logic        overflow_q, overflow_d;

  assign {as_n_s, uds_n_s, lds_n_s, rnw_s} = strb_sync_q;
  assign byte_addr_s = {addr_q, 1'b0};
  // Low bits of the 24-bit difference are all the VRAM address needs.
  assign off_lo_s    = byte_addr_s[14:0] - FB_BASE[14:0];
  assign hit_s       = fb_hit(byte_addr_s, FB_BASE);
  assign wr_detect_s = ~as_n_s & ~rnw_s & (~uds_n_s | ~lds_n_s);

  // Two-flop synchronisers for the strobes (idle high); address/data registered once.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      strb_meta_q <= 4'hF;
      strb_sync_q <= 4'hF;
      addr_q      <= 23'd0;
      data_q      <= 16'd0;
    end else begin
      strb_meta_q <= {nAS, nUDS, nLDS, cpuRnW};
      strb_sync_q <= strb_meta_q;
      addr_q      <= cpuAddr;
      data_q      <= cpuData;
    end
  end

  // Capture FSM: one detection per bus cycle, then push the selected bytes.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    uds_sel_d   = uds_sel_q;
    lds_sel_d   = lds_sel_q;
    push_s      = 1'b0;
    push_data_s = {ENTRY_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (wr_detect_s && hit_s) begin
          state_d   = ST_PUSH_HI;
          offset_d  = off_lo_s;
          wdata_d   = data_q;
          uds_sel_d = ~uds_n_s;
          lds_sel_d = ~lds_n_s;
        end else if (wr_detect_s) begin
          state_d = ST_WAIT_END;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PUSH_HI: begin
        if (uds_sel_q) begin
          push_s      = 1'b1;
          push_data_s = {offset_q, wdata_q[15:8]};
        end else begin
          push_s = 1'b0;
        end
        state_d = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        if (lds_sel_q) begin
          push_s      = 1'b1;
          push_data_s = {offset_q + 15'd1, wdata_q[7:0]};
        end else begin
          push_s = 1'b0;
        end
        state_d = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (as_n_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_END;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture FSM registers.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      offset_q  <= 15'd0;
      wdata_q   <= 16'd0;
      uds_sel_q <= 1'b0;
      lds_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      wdata_q   <= wdata_d;
      uds_sel_q <= uds_sel_d;
      lds_sel_q <= lds_sel_d;
    end
  end

  snoop_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pixClock),
    .rst_n (nReset),
    .push  (push_s),
    .din   (push_data_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // The slot's entry leaves the FIFO on the edge that samples seq 4.
  assign pop_s = (seq == SLOT_END) & slot_q;

  // Write-slot decode from the sampled seq phase; outputs register one edge later.
  always_comb begin
    slot_d          = 1'b0;
    vram_addr_sel_d = 1'b0;
    nvram_we_d      = 1'b1;
    vram_wr_addr_d  = vram_wr_addr_q;
    vram_wr_data_d  = vram_wr_data_q;
    case (seq)
      SLOT_START: begin
        if (!fifo_empty_s) begin
          slot_d          = 1'b1;
          vram_addr_sel_d = 1'b1;
          vram_wr_addr_d  = fifo_dout_s[22:8];
          vram_wr_data_d  = fifo_dout_s[7:0];
        end else begin
          slot_d          = 1'b0;
          vram_addr_sel_d = 1'b0;
        end
      end
      SLOT_WE: begin
        slot_d          = slot_q;
        vram_addr_sel_d = slot_q;
        nvram_we_d      = ~slot_q;
      end
      SLOT_END: begin
        slot_d          = 1'b0;
        vram_addr_sel_d = slot_q;
      end
      default: begin
        slot_d          = 1'b0;
        vram_addr_sel_d = 1'b0;
      end
    endcase
  end

  // A dropped push is one that finds the FIFO full with no pop to make room.
  always_comb begin
    overflow_d = overflow_q | (push_s & fifo_full_s & ~pop_s);
  end

  // Slot and overflow registers; reset releases the write strobe at once.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      slot_q          <= 1'b0;
      vram_wr_addr_q  <= 15'd0;
      vram_wr_data_q  <= 8'd0;
      vram_addr_sel_q <= 1'b0;
      nvram_we_q      <= 1'b1;
      overflow_q      <= 1'b0;
    end else begin
      slot_q          <= slot_d;
      vram_wr_addr_q  <= vram_wr_addr_d;
      vram_wr_data_q  <= vram_wr_data_d;
      vram_addr_sel_q <= vram_addr_sel_d;
      nvram_we_q      <= nvram_we_d;
      overflow_q      <= overflow_d;
    end
  end

  assign vramWrAddr  = vram_wr_addr_q;
  assign vramWrData  = vram_wr_data_q;
  assign vramAddrSel = vram_addr_sel_q;
  assign nvramWE     = nvram_we_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_cpu_snoop.sv
// Self-checking bench for cpu_snoop: directed cases plus random bus writes,
// checked against a byte-level model of which VRAM writes should appear.
module tb_cpu_snoop;

  localparam logic [23:0] BASE = 24'h3FA700;
  localparam int unsigned WIN  = 21888;
  localparam int unsigned CAP  = 8;

  logic        pixClock;
  logic        nReset;
  logic [22:0] cpuAddr;
  logic [15:0] cpuData;
  logic        nAS, nUDS, nLDS, cpuRnW;
  logic [2:0]  seq;
  logic [14:0] vramWrAddr;
  logic [7:0]  vramWrData;
  logic        vramAddrSel, nvramWE, overflow;

  int          total = 0;
  int          bad   = 0;
  logic [22:0] exp_q[$];
  logic [22:0] obs_q[$];
  logic        exp_ovf = 1'b0;
  logic        seq_run = 1'b1;
  logic [2:0]  seq_sampled = 3'd0;

  cpu_snoop #(
    .FB_BASE    (BASE),
    .FIFO_DEPTH (8)
  ) dut (
    .pixClock    (pixClock),
    .nReset      (nReset),
    .cpuAddr     (cpuAddr),
    .cpuData     (cpuData),
    .nAS         (nAS),
    .nUDS        (nUDS),
    .nLDS        (nLDS),
    .cpuRnW      (cpuRnW),
    .seq         (seq),
    .vramWrAddr  (vramWrAddr),
    .vramWrData  (vramWrData),
    .vramAddrSel (vramAddrSel),
    .nvramWE     (nvramWE),
    .overflow    (overflow)
  );

  initial begin
    pixClock = 1'b0;
    forever #5 pixClock = ~pixClock;
  end

  // Slot phase counter; held at 0 when slots are starved.
  initial begin
    seq = 3'd0;
    forever begin
      @(posedge pixClock);
      seq_sampled = seq;
      #1;
      seq = seq_run ? seq + 3'd1 : 3'd0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record every VRAM write and check its phase within the group.
  always @(negedge pixClock) begin
    if (nReset === 1'b1) begin
      if (nvramWE === 1'b0) begin
        obs_q.push_back({vramWrAddr, vramWrData});
        check_eq("we_phase", {29'd0, seq_sampled}, 32'd3);
        check_eq("we_sel", {31'd0, vramAddrSel}, 32'd1);
      end
      if (vramAddrSel === 1'b1) begin
        check_eq("sel_phase", {31'd0, (seq_sampled >= 3'd2 && seq_sampled <= 3'd4)}, 32'd1);
      end
    end
  end

  // Byte-level model: which VRAM bytes a bus cycle should produce.
  task automatic model_cycle(input logic [23:0] addr, input logic [15:0] data,
                             input logic rnw, input logic udsn, input logic ldsn);
    int unsigned a, off;
    logic [14:0] o15;
    a = addr;
    if (!rnw && (!udsn || !ldsn) && a >= BASE && (a - BASE) < WIN) begin
      off = a - BASE;
      o15 = off[14:0];
      if (!udsn) begin
        if (exp_q.size() - obs_q.size() < CAP) exp_q.push_back({o15, data[15:8]});
        else exp_ovf = 1'b1;
      end
      if (!ldsn) begin
        if (exp_q.size() - obs_q.size() < CAP) exp_q.push_back({o15 + 15'd1, data[7:0]});
        else exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic bus_cycle(input logic [23:0] addr, input logic [15:0] data, input logic rnw,
                           input logic udsn, input logic ldsn, input int hold);
    model_cycle(addr, data, rnw, udsn, ldsn);
    @(negedge pixClock);
    cpuAddr = addr[23:1];
    cpuData = data;
    cpuRnW  = rnw;
    @(negedge pixClock);
    nAS  = 1'b0;
    nUDS = udsn;
    nLDS = ldsn;
    repeat (hold) @(negedge pixClock);
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; cpuRnW = 1'b1;
    repeat (4) @(negedge pixClock);
  endtask

  task automatic drain_and_compare(input string tag);
    int n;
    for (int i = 0; i < 400; i++) begin
      if (obs_q.size() >= exp_q.size()) break;
      @(negedge pixClock);
    end
    repeat (32) @(negedge pixClock);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_byte"}, {9'd0, obs_q[i]}, {9'd0, exp_q[i]});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [23:0] addr;
    logic [15:0] data;
    logic        udsn, ldsn;
    int          found;
    nReset = 1'b0;
    cpuAddr = 23'd0; cpuData = 16'd0;
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; cpuRnW = 1'b1;
    repeat (3) @(negedge pixClock);
    check_eq("rst_we_in", {31'd0, nvramWE}, 32'd1);
    nReset = 1'b1;
    repeat (2) @(negedge pixClock);
    check_eq("rst_we", {31'd0, nvramWE}, 32'd1);
    check_eq("rst_sel", {31'd0, vramAddrSel}, 32'd0);
    check_eq("rst_addr", {17'd0, vramWrAddr}, 32'd0);
    check_eq("rst_data", {24'd0, vramWrData}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);

    // Word write at the buffer base.
    bus_cycle(BASE, 16'hA55A, 1'b0, 1'b0, 1'b0, 6);
    drain_and_compare("word_base");

    // Low byte only, one line in.
    bus_cycle(BASE + 24'h40, 16'hFF3C, 1'b0, 1'b1, 1'b0, 6);
    drain_and_compare("byte_lds");

    // Window edges and a read cycle.
    bus_cycle(24'h3FA6FE, 16'h1234, 1'b0, 1'b0, 1'b0, 6);
    bus_cycle(BASE + 24'd21888, 16'h5678, 1'b0, 1'b0, 1'b0, 6);
    bus_cycle(BASE + 24'h100, 16'h9ABC, 1'b1, 1'b0, 1'b0, 6);
    drain_and_compare("out_of_range");
    bus_cycle(BASE + 24'd21886, 16'hC3E1, 1'b0, 1'b0, 1'b0, 6);
    drain_and_compare("last_word");

    // Long address strobe must be captured only once.
    bus_cycle(BASE + 24'h80, 16'hBEEF, 1'b0, 1'b0, 1'b0, 40);
    drain_and_compare("long_as");

    // Randomised writes, mostly inside the window.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: addr = 24'($urandom()) & 24'hFFFFFE;
        1: addr = BASE - 24'd2;
        2: addr = BASE + 24'd21888;
        default: addr = BASE + 24'(2 * $urandom_range(0, 10943));
      endcase
      data = 16'($urandom());
      udsn = 1'($urandom_range(0, 1));
      ldsn = 1'($urandom_range(0, 1));
      bus_cycle(addr, data, 1'($urandom_range(0, 4) == 0), udsn, ldsn, $urandom_range(4, 8));
      drain_and_compare("random");
    end

    // Starved slots: nine word writes, only eight bytes fit.
    seq_run = 1'b0;
    repeat (2) @(negedge pixClock);
    for (int i = 0; i < 9; i++) begin
      bus_cycle(BASE + 24'h200 + 24'(2 * i), {4'hA, 4'(i), 4'h5, 4'(i)}, 1'b0, 1'b0, 1'b0, 4);
    end
    check_eq("starve_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
    check_eq("starve_kept", exp_q.size(), CAP);
    seq_run = 1'b1;
    drain_and_compare("starve_drain");
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset in the middle of a write slot.
    bus_cycle(BASE + 24'h300, 16'h1357, 1'b0, 1'b0, 1'b0, 6);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pixClock);
      if (nvramWE === 1'b0) begin
        found = 1;
        break;
      end
    end
    check_eq("slot_seen", found, 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    check_eq("midrst_we", {31'd0, nvramWE}, 32'd1);
    check_eq("midrst_sel", {31'd0, vramAddrSel}, 32'd0);
    check_eq("midrst_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge pixClock);
    nReset = 1'b1;
    obs_q.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
    drain_and_compare("after_rst");
    check_eq("after_rst_ovf", {31'd0, overflow}, {31'd0, exp_ovf});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_snoop.md
CPU_SNOOP -- requirements
Module: cpu_snoop

Interface
REQ-001 Parameter FB_BASE, default 24'h3FA700, byte address of the SE main screen buffer (4 MB configuration).
REQ-002 Parameter FIFO_DEPTH, default 8, byte-entry count of the write buffer; power of two, 4..16.
REQ-003 pixClock  in  1  pixel clock; the only clock; all logic on its rising edge.
REQ-004 nReset  in  1  asynchronous active-low reset.
REQ-005 cpuAddr  in  23  68000 address A[23:1], asynchronous to pixClock.
REQ-006 cpuData  in  16  68000 data D[15:0], asynchronous.
REQ-007 nAS, nUDS, nLDS, cpuRnW  in  1 each  68000 bus strobes and direction, asynchronous.
REQ-008 seq  in  3  hCount[2:0] from the timing generator; 8-pixel slot phase.
REQ-009 vramWrAddr  out  15  VRAM byte address for the write slot.
REQ-010 vramWrData  out  8  VRAM write data.
REQ-011 vramAddrSel  out  1  high selects vramWrAddr into the external VRAM address mux.
REQ-012 nvramWE  out  1  active-low VRAM write strobe.
REQ-013 overflow  out  1  sticky flag; a snooped byte was dropped.

Function
REQ-014 nAS, nUDS, nLDS and cpuRnW SHALL pass through two-flop synchronisers; cpuAddr and cpuData SHALL be registered once per clock, with no further synchronisation.
REQ-015 A write cycle SHALL be detected when synchronised nAS=0, cpuRnW=0 and (nUDS=0 or nLDS=0) while the FSM is in IDLE.
REQ-016 On detection: offset = {cpuAddr,1'b0} - FB_BASE, computed at 24 bits; in range iff FB_BASE <= address and offset < 21888 (342 lines x 64 bytes).
REQ-017 The FSM states SHALL be IDLE, PUSH_HI, PUSH_LO and WAIT_END.
REQ-018 FSM transitions:
  - IDLE to PUSH_HI on an in-range detection, latching offset[14:0], the data, and the UDS/LDS selects.
  - IDLE to WAIT_END on an out-of-range detection.
REQ-019 PUSH_HI SHALL push {offset, data[15:8]} if UDS is selected, then go to PUSH_LO; it takes one cycle.
REQ-020 PUSH_LO SHALL push {offset+1, data[7:0]} if LDS is selected, then go to WAIT_END; it takes one cycle.
REQ-021 WAIT_END SHALL return to IDLE once synchronised nAS=1, so each bus cycle is captured exactly once.
REQ-022 A push into a full FIFO SHALL drop the byte, set overflow=1, and leave FIFO contents unchanged.
REQ-023 Write slot:
  - When seq==2 and the FIFO is not empty, latch the head entry onto vramWrAddr/vramWrData.
  - vramAddrSel SHALL be high for seq 2..4 inclusive.
  - nvramWE SHALL be low for seq 3 only.
  - Pop at the end of seq 4.
  - All these outputs are registered and are decoded from the seq value sampled on the same edge.
REQ-024 Slots SHALL never overlap seq 7, the video read phase; at most one byte is written per 8-pixel group.
REQ-025 A push and a pop on the same cycle SHALL both take effect; the count is unchanged, and this holds even when the FIFO is full.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order is strictly first-in, first-out.
REQ-027 The FIFO empty at seq==2 SHALL mean no slot is started for that group, and the outputs hold their idle values.

Reset
REQ-028 On nReset=0 the block SHALL asynchronously enter IDLE, empty the FIFO, and set the synchronisers to 1 (strobes inactive).
REQ-029 On nReset=0 the outputs SHALL be nvramWE=1, vramAddrSel=0, vramWrAddr=0, vramWrData=0, overflow=0.
REQ-030 Reset asserted mid-slot SHALL release nvramWE immediately and discard the entry in progress.
REQ-031 overflow SHALL clear only on reset.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, FB_BYTES=21888, LINE_BYTES=64, and the slot phase constants SLOT_START=2, SLOT_WE=3, SLOT_END=4.
REQ-033 The FIFO SHALL be a separate sub-module, snoop_fifo (23-bit entries, push/pop/full/empty, async reset).

Verification
REQ-034 Word write to 24'h3FA700 with data 16'hA55A -> VRAM bytes 0x0000=A5 and 0x0001=5A, each nvramWE pulse at seq 3 of successive groups.
REQ-035 Byte write (nLDS only) to 24'h3FA700+0x40 with data 16'hxx3C -> a single write at vramWrAddr 0x0041 with data 3C; nothing written at 0x0040.
REQ-036 Writes to 24'h3FA6FE and to 24'h3FA700+21888 -> no pushes and no nvramWE activity; a read cycle at an in-range address -> no pushes.
REQ-037 Nine word writes back-to-back with slots starved (seq held at 0) -> eight bytes retained, overflow=1; after slots resume, the bytes drain in order.
REQ-038 nAS held low for 40 clocks on one write -> exactly one capture.
REQ-039 nReset pulsed during seq 3 of a slot -> nvramWE=1 within the reset assertion, FIFO empty, overflow=0.
